axi_2to1_arbiter: RTL and testbench

Two-master, one-slave AXI arbiter placed in front of the AXI-SRAM bridge so that two requesters (e.g. instruction fetch on m0, data port on m1) can share a single bridge. Read (AR/R) and write (AW/W/B) paths are arbitrated independently. Each path carries at most one outstanding transaction. The grant is held from address handshake through the final R beat or the B response.

---
 rtl/axi_2to1_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_axi_2to1_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_2to1_arbiter.sv
// axi_2to1_arbiter: two AXI masters (m0, m1) share one slave port (s_*).
// Read (AR/R) and write (AW/W/B) paths are arbitrated independently,
// one outstanding transaction per path, grant held until R last / B.
// Ports: clk, resetn (async, active-low); per master m0_/m1_ AR, R, AW,
// W, B channels; s_* are the slave-side copies toward the bridge.
// Config: define ARB_FIXED_PRIORITY_EN for fixed m0 priority on both
// paths; otherwise round-robin with a 1-bit pointer per path.
module axi_2to1_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_rlast,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    input  logic [ADDR_W-1:0] m0_awaddr,
    input  logic              m0_awvalid,
    output logic              m0_awready,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_wlast,
    input  logic              m0_wvalid,
    output logic              m0_wready,
    output logic              m0_bvalid,
    input  logic              m0_bready,
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_rlast,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    input  logic [ADDR_W-1:0] m1_awaddr,
    input  logic              m1_awvalid,
    output logic              m1_awready,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_wlast,
    input  logic              m1_wvalid,
    output logic              m1_wready,
    output logic              m1_bvalid,
    input  logic              m1_bready,
    output logic [ADDR_W-1:0] s_araddr,
    output logic              s_arvalid,
    input  logic              s_arready,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic              s_rlast,
    input  logic              s_rvalid,
    output logic              s_rready,
    output logic [ADDR_W-1:0] s_awaddr,
    output logic              s_awvalid,
    input  logic              s_awready,
    output logic [DATA_W-1:0] s_wdata,
    output logic              s_wlast,
    output logic              s_wvalid,
    input  logic              s_wready,
    input  logic              s_bvalid,
    output logic              s_bready
);

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wstate_t;

    rstate_t rstate;
    wstate_t wstate;
    logic    rgnt;
    logic    wgnt;
    logic    aw_done;
    logic    w_done;

    logic r_pick;
    logic w_pick;
    logic r_end;
    logic w_end;
    logic aw_hs;
    logic wl_hs;
    logic w_go;

    logic r_addr;
    logic r_data;
    logic w_addr;
    logic w_resp;
    logic aw_open;
    logic w_open;

`ifdef ARB_FIXED_PRIORITY_EN
    // m0 wins every tie; m1 only when m0 is not asking
    assign r_pick = ~m0_arvalid;
    assign w_pick = ~m0_awvalid;
`else
    logic rptr;
    logic wptr;

    assign r_pick = (m0_arvalid & m1_arvalid) ? rptr : m1_arvalid;
    assign w_pick = (m0_awvalid & m1_awvalid) ? wptr : m1_awvalid;

    // Next tie goes to whoever was not just served
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rptr <= 1'b0;
            wptr <= 1'b0;
        end else begin
            if (r_end) rptr <= ~rgnt;
            if (w_end) wptr <= ~wgnt;
        end
    end
`endif

    assign r_addr  = (rstate == R_ADDR);
    assign r_data  = (rstate == R_DATA);
    assign w_addr  = (wstate == W_ADDR);
    assign w_resp  = (wstate == W_RESP);
    // Each channel stops forwarding once its part of the burst is done
    assign aw_open = w_addr & ~aw_done;
    assign w_open  = w_addr & ~w_done;

    assign r_end = r_data & s_rvalid & s_rready & s_rlast;
    assign w_end = w_resp & s_bvalid & s_bready;
    assign aw_hs = s_awvalid & s_awready;
    assign wl_hs = s_wvalid & s_wready & s_wlast;
    assign w_go  = (aw_done | aw_hs) & (w_done | wl_hs);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rstate <= R_IDLE;
            rgnt   <= 1'b0;
        end else begin
            unique case (rstate)
                R_IDLE: if (m0_arvalid | m1_arvalid) begin
                    rgnt   <= r_pick;
                    rstate <= R_ADDR;
                end
                R_ADDR: if (s_arvalid & s_arready) rstate <= R_DATA;
                R_DATA: if (r_end) rstate <= R_IDLE;
                default: rstate <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wstate  <= W_IDLE;
            wgnt    <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            unique case (wstate)
                W_IDLE: if (m0_awvalid | m1_awvalid) begin
                    wgnt   <= w_pick;
                    wstate <= W_ADDR;
                end
                W_ADDR: if (w_go) begin
                    wstate  <= W_RESP;
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                end else begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (wl_hs) w_done  <= 1'b1;
                end
                W_RESP: if (w_end) wstate <= W_IDLE;
                default: wstate <= W_IDLE;
            endcase
        end
    end

    assign s_araddr   = rgnt ? m1_araddr : m0_araddr;
    assign s_arvalid  = r_addr & (rgnt ? m1_arvalid : m0_arvalid);
    assign m0_arready = r_addr & ~rgnt & s_arready;
    assign m1_arready = r_addr & rgnt & s_arready;

    assign s_rready  = r_data & (rgnt ? m1_rready : m0_rready);
    assign m0_rdata  = s_rdata;
    assign m1_rdata  = s_rdata;
    assign m0_rvalid = r_data & ~rgnt & s_rvalid;
    assign m1_rvalid = r_data & rgnt & s_rvalid;
    assign m0_rlast  = r_data & ~rgnt & s_rlast;
    assign m1_rlast  = r_data & rgnt & s_rlast;

    assign s_awaddr   = wgnt ? m1_awaddr : m0_awaddr;
    assign s_awvalid  = aw_open & (wgnt ? m1_awvalid : m0_awvalid);
    assign m0_awready = aw_open & ~wgnt & s_awready;
    assign m1_awready = aw_open & wgnt & s_awready;

    assign s_wdata   = wgnt ? m1_wdata : m0_wdata;
    assign s_wlast   = w_addr & (wgnt ? m1_wlast : m0_wlast);
    assign s_wvalid  = w_open & (wgnt ? m1_wvalid : m0_wvalid);
    assign m0_wready = w_open & ~wgnt & s_wready;
    assign m1_wready = w_open & wgnt & s_wready;

    assign s_bready  = w_resp & (wgnt ? m1_bready : m0_bready);
    assign m0_bvalid = w_resp & ~wgnt & s_bvalid;
    assign m1_bvalid = w_resp & wgnt & s_bvalid;

endmodule

// File: tb/tb_axi_2to1_arbiter.sv
// tb_axi_2to1_arbiter: directed bench for axi_2to1_arbiter with a small
// single-beat SRAM slave model on the s_* side.
module tb_axi_2to1_arbiter;

`ifdef ARB_FIXED_PRIORITY_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    localparam logic [63:0] D0 = 64'h12345678;
    localparam logic [63:0] DA = 64'hDEAD_0001_0000_0010;
    localparam logic [63:0] DB = 64'hBEEF_0000_0000_0018;
    localparam logic [63:0] DC = 64'hCAFE_F00D_0000_0020;
    localparam logic [63:0] DD = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] M2 = 64'hA000_0000_0000_0002;
    localparam logic [63:0] M3 = 64'hA000_0000_0000_0003;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] m0_araddr, m1_araddr, m0_awaddr, m1_awaddr;
    logic        m0_arvalid, m0_arready, m1_arvalid, m1_arready;
    logic [63:0] m0_rdata, m1_rdata, m0_wdata, m1_wdata;
    logic        m0_rlast, m0_rvalid, m0_rready;
    logic        m1_rlast, m1_rvalid, m1_rready;
    logic        m0_awvalid, m0_awready, m1_awvalid, m1_awready;
    logic        m0_wlast, m0_wvalid, m0_wready;
    logic        m1_wlast, m1_wvalid, m1_wready;
    logic        m0_bvalid, m0_bready, m1_bvalid, m1_bready;
    logic [31:0] s_araddr, s_awaddr;
    logic        s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
    logic [63:0] s_rdata, s_wdata;
    logic        s_awvalid, s_awready, s_wlast, s_wvalid, s_wready;
    logic        s_bvalid, s_bready;

    int n_assert = 0;
    int n_fail   = 0;
    bit sec;

    always #5 clk = ~clk;

    axi_2to1_arbiter #(.ADDR_W(32), .DATA_W(64)) dut (
        .clk(clk), .resetn(resetn),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid),
        .m0_arready(m0_arready), .m0_rdata(m0_rdata),
        .m0_rlast(m0_rlast), .m0_rvalid(m0_rvalid),
        .m0_rready(m0_rready), .m0_awaddr(m0_awaddr),
        .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
        .m0_wdata(m0_wdata), .m0_wlast(m0_wlast),
        .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
        .m0_bvalid(m0_bvalid), .m0_bready(m0_bready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid),
        .m1_arready(m1_arready), .m1_rdata(m1_rdata),
        .m1_rlast(m1_rlast), .m1_rvalid(m1_rvalid),
        .m1_rready(m1_rready), .m1_awaddr(m1_awaddr),
        .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
        .m1_wdata(m1_wdata), .m1_wlast(m1_wlast),
        .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
        .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid),
        .s_arready(s_arready), .s_rdata(s_rdata),
        .s_rlast(s_rlast), .s_rvalid(s_rvalid),
        .s_rready(s_rready), .s_awaddr(s_awaddr),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wlast(s_wlast),
        .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bready(s_bready)
    );

    // Slave model: always-ready address/data, single-beat reads,
    // B one cycle after both AW and last W have been accepted.
    logic [63:0] mem [0:63];
    logic [31:0] slv_wa, slv_wa_now;
    logic        slv_aw, slv_w;

    assign s_arready  = 1'b1;
    assign s_awready  = 1'b1;
    assign s_wready   = 1'b1;
    assign slv_wa_now = (s_awvalid && s_awready) ? s_awaddr : slv_wa;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s_rvalid <= 1'b0;
            s_rlast  <= 1'b0;
            s_rdata  <= '0;
            s_bvalid <= 1'b0;
            slv_wa   <= '0;
            slv_aw   <= 1'b0;
            slv_w    <= 1'b0;
        end else begin
            if (s_arvalid && s_arready) begin
                s_rvalid <= 1'b1;
                s_rlast  <= 1'b1;
                s_rdata  <= mem[s_araddr[7:2]];
            end else if (s_rvalid && s_rready) begin
                s_rvalid <= 1'b0;
                s_rlast  <= 1'b0;
            end
            if (s_awvalid && s_awready) begin
                slv_wa <= s_awaddr;
                slv_aw <= 1'b1;
            end
            if (s_wvalid && s_wready && s_wlast) slv_w <= 1'b1;
            if (slv_aw && slv_w && !s_bvalid) begin
                s_bvalid <= 1'b1;
                slv_aw   <= 1'b0;
                slv_w    <= 1'b0;
            end else if (s_bvalid && s_bready) begin
                s_bvalid <= 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (s_wvalid && s_wready) mem[slv_wa_now[7:2]] <= s_wdata;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] ctl();
        return {s_arvalid, s_rready, s_awvalid, s_wvalid, s_wlast,
                s_bready, m0_arready, m0_rvalid, m0_rlast, m0_awready,
                m0_wready, m0_bvalid, m1_arready, m1_rvalid, m1_rlast,
                m1_awready, m1_wready, m1_bvalid};
    endfunction

    function automatic logic [5:0] m1q();
        return {m1_arready, m1_rvalid, m1_rlast,
                m1_awready, m1_wready, m1_bvalid};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: run did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = {32'hA000_0000, i};
        resetn = 1'b0;
        m0_araddr = 32'h10; m1_araddr = 32'h20;
        m0_awaddr = 32'h10; m1_awaddr = 32'h20;
        m0_wdata = 64'h55; m1_wdata = 64'h66;
        {m0_arvalid, m0_rready, m0_awvalid, m0_wlast} = '0;
        {m0_wvalid, m0_bready, m1_arvalid, m1_rready} = '0;
        {m1_awvalid, m1_wlast, m1_wvalid, m1_bready} = '0;
        #1;
        chk("reset_ctl", 64'(ctl()), 64'h0);
        chk("reset_araddr", 64'(s_araddr), 64'h10);
        chk("reset_wdata", s_wdata, 64'h55);
        step;
        step;
        resetn = 1'b1;

        // single write then read by m0
        m0_awaddr = 32'h4; m0_awvalid = 1; m0_wdata = D0;
        m0_wlast = 1; m0_wvalid = 1; m0_bready = 1;
        step;
        chk("t1_awvalid", 64'(s_awvalid), 64'h1);
        chk("t1_awaddr", 64'(s_awaddr), 64'h4);
        chk("t1_wvalid", 64'(s_wvalid), 64'h1);
        chk("t1_wdata", s_wdata, D0);
        chk("t1_m0_rdy", 64'({m0_awready, m0_wready}), 64'h3);
        chk("t1_m1_quiet_a", 64'(m1q()), 64'h0);
        step;
        m0_awvalid = 0; m0_wvalid = 0; m0_wlast = 0;
        chk("t1_no_b_yet", 64'(m0_bvalid), 64'h0);
        chk("t1_aw_closed", 64'(s_awvalid), 64'h0);
        step;
        chk("t1_bvalid", 64'(m0_bvalid), 64'h1);
        chk("t1_bready", 64'(s_bready), 64'h1);
        chk("t1_m1_quiet_b", 64'(m1q()), 64'h0);
        step;
        chk("t1_b_once", 64'(m0_bvalid), 64'h0);
        chk("t1_widle", 64'(s_bready), 64'h0);
        m0_araddr = 32'h4; m0_arvalid = 1; m0_rready = 1;
        step;
        chk("t1_arvalid", 64'(s_arvalid), 64'h1);
        chk("t1_araddr", 64'(s_araddr), 64'h4);
        chk("t1_arready", 64'(m0_arready), 64'h1);
        step;
        m0_arvalid = 0;
        chk("t1_rvalid", 64'(m0_rvalid), 64'h1);
        chk("t1_rdata", m0_rdata, D0);
        chk("t1_rlast", 64'(m0_rlast), 64'h1);
        chk("t1_m1_quiet_c", 64'(m1q()), 64'h0);
        step;
        chk("t1_r_done", 64'(m0_rvalid), 64'h0);

        // simultaneous reads from reset
        resetn = 0;
        step;
        resetn = 1;
        m0_araddr = 32'h4; m0_arvalid = 1; m0_rready = 1;
        m1_araddr = 32'h8; m1_arvalid = 1; m1_rready = 1;
        step;
        chk("t2_first_addr", 64'(s_araddr), 64'h4);
        chk("t2_first_rdy", 64'({m0_arready, m1_arready}), 64'h2);
        step;
        m0_araddr = 32'hC;
        chk("t2_first_data", m0_rdata, D0);
        chk("t2_first_rv", 64'({m0_rvalid, m1_rvalid}), 64'h2);
        step;
        chk("t2_gap", 64'(s_arvalid), 64'h0);
        sec = FIXED ? 1'b0 : 1'b1;
        step;
        chk("t2_second_addr", 64'(s_araddr),
            sec ? 64'h8 : 64'hC);
        chk("t2_second_rdy", 64'({m0_arready, m1_arready}),
            sec ? 64'h1 : 64'h2);
        step;
        if (sec) m1_arvalid = 0; else m0_arvalid = 0;
        chk("t2_second_rv", 64'({m0_rvalid, m1_rvalid}),
            sec ? 64'h1 : 64'h2);
        chk("t2_second_data", s_rdata, sec ? M2 : M3);
        step;
        step;
        chk("t2_third_addr", 64'(s_araddr),
            sec ? 64'hC : 64'h8);
        chk("t2_third_rdy", 64'({m0_arready, m1_arready}),
            sec ? 64'h2 : 64'h1);
        step;
        m0_arvalid = 0; m1_arvalid = 0;
        chk("t2_third_data", s_rdata, sec ? M3 : M2);
        step;

        // long bready on m1 with an m0 write waiting
        m1_awaddr = 32'h10; m1_awvalid = 1; m1_wdata = DA;
        m1_wlast = 1; m1_wvalid = 1; m1_bready = 0;
        step;
        chk("t3_m1_granted", 64'({m0_awready, m1_awready}), 64'h1);
        m0_awaddr = 32'h18; m0_awvalid = 1; m0_wdata = DB;
        m0_wlast = 1; m0_wvalid = 1; m0_bready = 1;
        step;
        m1_awvalid = 0; m1_wvalid = 0; m1_wlast = 0;
        step;
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_sb", 64'({s_bvalid, m1_bvalid}), 64'h3);
            chk("t3_hold_m0", 64'({s_awvalid, m0_awready}), 64'h0);
            step;
        end
        m1_bready = 1;
        #1;
        chk("t3_bready", 64'(s_bready), 64'h1);
        step;
        chk("t3_b_done", 64'(m1_bvalid), 64'h0);
        chk("t3_idle_gap", 64'(s_awvalid), 64'h0);
        step;
        chk("t3_m0_aw", 64'({s_awvalid, m0_awready, m1_awready}), 64'h6);
        chk("t3_m0_addr", 64'(s_awaddr), 64'h18);
        step;
        m0_awvalid = 0; m0_wvalid = 0; m0_wlast = 0;
        step;
        chk("t3_m0_b", 64'({m0_bvalid, m1_bvalid}), 64'h2);
        step;

        // AW before W on m1
        m1_awaddr = 32'h20; m1_awvalid = 1; m1_bready = 1;
        step;
        chk("t4_aw", 64'({s_awvalid, m1_awready, s_wvalid}), 64'h6);
        step;
        m1_awvalid = 0;
        chk("t4_aw_done", 64'(dut.aw_done), 64'h1);
        chk("t4_no_resp", 64'({s_bready, s_awvalid}), 64'h0);
        step;
        chk("t4_wait_w", 64'({s_bready, s_wvalid}), 64'h0);
        m1_wdata = DC; m1_wlast = 1; m1_wvalid = 1;
        #1;
        chk("t4_w", 64'({s_wvalid, m1_wready}), 64'h3);
        step;
        m1_wvalid = 0; m1_wlast = 0;
        chk("t4_resp", 64'({s_bready, dut.aw_done}), 64'h2);
        step;
        chk("t4_bvalid", 64'(m1_bvalid), 64'h1);
        step;

        // concurrent m0 read and m1 write
        m0_araddr = 32'h20; m0_arvalid = 1; m0_rready = 1;
        m1_awaddr = 32'h28; m1_awvalid = 1; m1_wdata = DD;
        m1_wlast = 1; m1_wvalid = 1; m1_bready = 1;
        step;
        chk("t5_both_addr",
            64'({m0_arready, m1_awready, m1_wready}), 64'h7);
        step;
        m0_arvalid = 0; m1_awvalid = 0;
        m1_wvalid = 0; m1_wlast = 0;
        chk("t5_rdata", m0_rdata, DC);
        chk("t5_rvalid", 64'({m0_rvalid, s_bready}), 64'h3);
        step;
        chk("t5_b", 64'({m0_rvalid, m1_bvalid}), 64'h1);
        step;

        // reset while m1 sits in R_DATA
        m1_araddr = 32'h28; m1_arvalid = 1; m1_rready = 0;
        step;
        chk("t6_arready", 64'(m1_arready), 64'h1);
        step;
        m1_arvalid = 0;
        step;
        chk("t6_stalled", 64'({m1_rvalid, s_rready}), 64'h2);
        resetn = 0;
        #1;
        chk("t6_reset_ctl", 64'(ctl()), 64'h0);
        step;
        resetn = 1;
`ifndef ARB_FIXED_PRIORITY_EN
        chk("t6_rptr", 64'(dut.rptr), 64'h0);
`endif
        m1_arvalid = 1; m1_rready = 1;
        step;
        chk("t6_fresh_ar", 64'({m1_arready, s_araddr}), 64'h1_0000_0028);
        step;
        m1_arvalid = 0;
        chk("t6_fresh_r", 64'({m1_rvalid, m1_rlast}), 64'h3);
        chk("t6_fresh_data", m1_rdata, DD);
        step;
        chk("t6_done", 64'(m1_rvalid), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
